// File: rtl/i2c_master_read_word_if.sv
// Bus/handshake bundle for the I2C word-read engine.
// The master modport is the engine side; the slave modport is the controller/bus side.
interface i2c_master_read_word_if #(parameter int DATA_WIDTH = 8);
   logic                  go;
   logic                  nack;
   logic                  busy;
   logic                  finish;
   logic [DATA_WIDTH-1:0] data;
   logic                  error;
   logic [1:0]            error_code;
   logic                  scl;
   logic                  scl_in;
   logic                  sda;
   logic                  sda_oe;

   modport master (input go, nack, scl_in, sda,
                   output busy, finish, data, error, error_code, scl, sda_oe);
   modport slave  (output go, nack, scl_in, sda,
                   input busy, finish, data, error, error_code, scl, sda_oe);
endinterface

// File: rtl/i2c_master_read_word.sv
// I2C receive engine: clocks in DATA_WIDTH bits MSB-first with majority sampling and
// clock-stretch timeout, then drives the ACK/NACK slot.
module i2c_master_read_word #(
   parameter int DATA_WIDTH      = 8,
   parameter int HALF_PERIOD     = 4,
   parameter int STRETCH_TIMEOUT = 1023
) (
   input  logic                          clock,
   input  logic                          reset,
   i2c_master_read_word_if.master        bus
);
   localparam int BW = $clog2(DATA_WIDTH + 1);
   localparam int CW = $clog2(HALF_PERIOD);
   localparam int OW = $clog2(HALF_PERIOD + 1);
   localparam int WW = $clog2(STRETCH_TIMEOUT + 1);
   localparam logic [BW-1:0] LAST_BIT = BW'(DATA_WIDTH);
   localparam logic [CW-1:0] HP_LAST  = CW'(HALF_PERIOD - 1);
   localparam logic [OW-1:0] HP_ONES  = OW'(HALF_PERIOD);
   localparam logic [OW-1:0] HI_MIN   = OW'(HALF_PERIOD - 1);
   localparam logic [OW-1:0] LO_MAX   = OW'(1);
   localparam logic [WW-1:0] TO_LAST  = WW'(STRETCH_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOW, STRETCH, HIGH, DONE} state_t;

   state_t                state_q, state_d;
   logic [BW-1:0]         bit_q, bit_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [WW-1:0]         wait_q, wait_d;
   logic [OW-1:0]         ones_q, ones_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] data_q, data_d;
   logic [1:0]            code_q, code_d;
   logic                  nack_q, nack_d;
   logic                  scl_q, scl_d;
   logic                  sda_oe_q, sda_oe_d;
   logic                  busy_q, busy_d;
   logic                  finish_q, finish_d;
   logic [OW-1:0]         ones_now;
   logic                  bit_now;

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      cnt_d    = cnt_q;
      wait_d   = wait_q;
      ones_d   = ones_q;
      shreg_d  = shreg_q;
      data_d   = data_q;
      code_d   = code_q;
      nack_d   = nack_q;
      ones_now = ones_q;
      bit_now  = 1'b0;
      case (state_q)
         IDLE: if (bus.go) begin
            nack_d  = bus.nack;
            code_d  = 2'b00;
            bit_d   = '0;
            cnt_d   = '0;
            state_d = LOW;
         end
         LOW: begin
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == HP_LAST) begin
               cnt_d   = '0;
               wait_d  = '0;
               state_d = STRETCH;
            end
         end
         STRETCH: begin
            wait_d = wait_q + 1'b1;
            if (bus.scl_in) begin
               ones_d  = '0;
               cnt_d   = '0;
               state_d = HIGH;
            end else if (wait_q == TO_LAST) begin
               code_d[1] = 1'b1;
               data_d    = '0;
               state_d   = DONE;
            end
         end
         HIGH: begin
            ones_now = (bus.sda && ones_q != HP_ONES) ? ones_q + 1'b1 : ones_q;
            ones_d   = ones_now;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == HP_LAST) begin
               cnt_d = '0;
               if (bit_q == LAST_BIT) begin
                  data_d  = shreg_q;
                  state_d = DONE;
               end else begin
                  // Anything between the two majority thresholds reads as 0 and flags the word.
                  bit_now = (ones_now >= HI_MIN);
                  if (!bit_now && ones_now > LO_MAX) code_d[0] = 1'b1;
                  shreg_d = (shreg_q << 1) | DATA_WIDTH'(bit_now);
                  bit_d   = bit_q + 1'b1;
                  state_d = LOW;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      // Outputs follow the next state so they line up with the state they describe.
      scl_d    = (state_d != LOW);
      sda_oe_d = (state_d == LOW || state_d == STRETCH || state_d == HIGH) &&
                 (bit_d == LAST_BIT) && !nack_d;
      busy_d   = (state_d != IDLE);
      finish_d = (state_d == DONE);
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q  <= IDLE;
         bit_q    <= '0;
         cnt_q    <= '0;
         wait_q   <= '0;
         ones_q   <= '0;
         shreg_q  <= '0;
         data_q   <= '0;
         code_q   <= 2'b00;
         nack_q   <= 1'b0;
         scl_q    <= 1'b1;
         sda_oe_q <= 1'b0;
         busy_q   <= 1'b0;
         finish_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bit_q    <= bit_d;
         cnt_q    <= cnt_d;
         wait_q   <= wait_d;
         ones_q   <= ones_d;
         shreg_q  <= shreg_d;
         data_q   <= data_d;
         code_q   <= code_d;
         nack_q   <= nack_d;
         scl_q    <= scl_d;
         sda_oe_q <= sda_oe_d;
         busy_q   <= busy_d;
         finish_q <= finish_d;
      end
   end

   assign bus.scl        = scl_q;
   assign bus.sda_oe     = sda_oe_q;
   assign bus.busy       = busy_q;
   assign bus.finish     = finish_q;
   assign bus.data       = data_q;
   assign bus.error_code = code_q;
   assign bus.error      = |code_q;
endmodule

// File: tb/tb_i2c_master_read_word.sv
// Randomized bench for the I2C word-read engine against a cycle-schedule reference model.
module tb_i2c_master_read_word;
   localparam int W = 8;
   localparam int H = 4;
   localparam int T = 1023;

   logic clock = 1'b0;
   logic rst   = 1'b1;
   logic hold  = 1'b0;
   int   vectors = 0;
   int   miscompares = 0;

   i2c_master_read_word_if #(.DATA_WIDTH(W)) bus ();

   assign bus.scl_in = bus.scl & ~hold;

   i2c_master_read_word #(.DATA_WIDTH(W), .HALF_PERIOD(H), .STRETCH_TIMEOUT(T)) dut (
      .clock (clock),
      .reset (rst),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
      end
   endtask

   // Per-cycle schedule, entry k describes cycle k+1 after accept.
   // exp bits: {busy, finish, scl, sda_oe}
   bit         q_sda[$];
   bit         q_hold[$];
   logic [3:0] q_exp[$];
   logic [W-1:0] m_data;
   logic [1:0]   m_code;

   task automatic build(input logic [W-1:0] word, input bit nk, input int amb_bit,
                        input int glitch_bit, input int st_bit, input int st_len);
      logic [H-1:0] pat;
      logic [W-1:0] acc;
      bit           amb, tmo, oe, bitv;
      int           ones, hl, p1, p2;
      q_sda.delete(); q_hold.delete(); q_exp.delete();
      acc = '0; amb = 0; tmo = 0;
      for (int b = 0; b <= W && !tmo; b++) begin
         oe = (b == W) && !nk;
         for (int i = 0; i < H; i++) begin
            q_sda.push_back(1'($urandom)); q_hold.push_back(0); q_exp.push_back({3'b100, oe});
         end
         hl = (b == st_bit) ? st_len : 0;
         if (hl >= T) begin
            for (int i = 0; i < T; i++) begin
               q_sda.push_back(1'($urandom)); q_hold.push_back(1); q_exp.push_back({3'b101, oe});
            end
            tmo = 1;
         end else begin
            for (int i = 0; i <= hl; i++) begin
               q_sda.push_back(1'($urandom)); q_hold.push_back(i < hl); q_exp.push_back({3'b101, oe});
            end
            pat = word[W-1-b] ? '1 : '0;
            if (b == amb_bit) begin
               p1 = $urandom_range(0, H-1);
               p2 = (p1 + 1 + $urandom_range(0, H-2)) % H;
               pat = '0; pat[p1] = 1'b1; pat[p2] = 1'b1;
            end else if (b == glitch_bit) begin
               p1 = $urandom_range(0, H-1);
               pat[p1] = ~pat[p1];
            end
            for (int i = 0; i < H; i++) begin
               q_sda.push_back(pat[i]); q_hold.push_back(0); q_exp.push_back({3'b101, oe});
            end
            if (b < W) begin
               ones = $countones(pat);
               bitv = (ones >= H-1);
               if (!bitv && ones > 1) amb = 1;
               acc = {acc[W-2:0], bitv};
            end
         end
      end
      q_sda.push_back(1); q_hold.push_back(0); q_exp.push_back(4'b1110);
      q_sda.push_back(1); q_hold.push_back(0); q_exp.push_back(4'b0010);
      m_data = tmo ? '0 : acc;
      m_code = {tmo, amb};
   endtask

   task automatic run_xfer(input logic [W-1:0] word, input bit nk, input int amb_bit,
                           input int glitch_bit, input int st_bit, input int st_len,
                           input bit noise, input int abort_at);
      int fin_cyc, exp_lat, done_idx;
      build(word, nk, amb_bit, glitch_bit, st_bit, st_len);
      done_idx = q_exp.size() - 2;
      if (st_len >= T) exp_lat = 1 + st_bit * (2*H + 1) + H + T;
      else             exp_lat = 1 + (W + 1) * (2*H + 1) + st_len;
      fin_cyc = -1;
      @(posedge clock); #1;
      bus.go = 1'b1; bus.nack = nk; bus.sda = 1'b1; hold = 1'b0;
      for (int c = 0; c < q_exp.size(); c++) begin
         @(posedge clock); #1;
         bus.go   = (noise && c < q_exp.size() - 1) ? 1'($urandom) : 1'b0;
         bus.nack = 1'($urandom);
         chk("ctl{busy,fin,scl,oe}", {bus.busy, bus.finish, bus.scl, bus.sda_oe}, q_exp[c]);
         if (bus.finish && fin_cyc < 0) fin_cyc = c + 1;
         if (c >= done_idx) begin
            chk("data", bus.data, m_data);
            chk("error_code", bus.error_code, m_code);
            chk("error", bus.error, |m_code);
         end
         bus.sda = q_sda[c]; hold = q_hold[c];
         if (abort_at != 0 && c + 1 == abort_at) begin
            rst = 1'b1; bus.go = 1'b0;
            @(posedge clock); #1;
            rst = 1'b0; hold = 1'b0;
            chk("rst_ctl", {bus.busy, bus.finish, bus.scl, bus.sda_oe}, 4'b0010);
            chk("rst_data", bus.data, '0);
            chk("rst_code", bus.error_code, 2'b00);
            for (int k = 0; k < 4; k++) begin
               @(posedge clock); #1;
               chk("rst_quiet", {bus.busy, bus.finish}, 2'b00);
            end
            return;
         end
      end
      hold = 1'b0;
      chk("latency", fin_cyc, exp_lat);
   endtask

   initial begin
      bus.go = 1'b0; bus.nack = 1'b0; bus.sda = 1'b1;
      repeat (3) @(posedge clock);
      #1;
      chk("reset_ctl", {bus.busy, bus.finish, bus.scl, bus.sda_oe}, 4'b0010);
      chk("reset_data", bus.data, '0);
      chk("reset_err", {bus.error, bus.error_code}, 3'b000);
      rst = 1'b0;
      // word, nack, amb_bit, glitch_bit, st_bit, st_len, noise, abort_at
      run_xfer(8'hA5, 0, -1, -1, -1, 0, 0, 0);
      run_xfer(8'h3C, 1, -1, -1, -1, 0, 0, 0);
      run_xfer(8'hA5, 0,  2, -1, -1, 0, 0, 0);
      run_xfer(8'hA5, 0, -1,  5, -1, 0, 0, 0);
      run_xfer(8'h5A, 0, -1, -1,  3, 10, 0, 0);
      run_xfer(8'hC3, 0, -1, -1,  3, T, 0, 0);
      run_xfer(8'h96, 1,  1, -1,  3, T, 0, 0);
      run_xfer(8'h69, 0, -1, -1,  6, T-1, 0, 0);
      run_xfer(8'hF0, 0, -1, -1,  8, 1, 1, 0);
      run_xfer(8'h81, 0, -1, -1, -1, 0, 0, 40);
      run_xfer(8'h7E, 0, -1, -1, -1, 0, 1, 0);
      for (int n = 0; n < 14; n++) begin
         run_xfer(8'($urandom), 1'($urandom),
                  ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, W-1)) : -1,
                  ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, W)) : -1,
                  int'($urandom_range(0, W)),
                  ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 20)) : 0,
                  1'($urandom), 0);
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog");
   end
endmodule
